// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: RAM handshake states, arbiter owner state,
// and the word type used on every cache/RAM data path.
package cpu_types_pkg;

    localparam int DATA_W               = 32;
    localparam int STARVE_LIMIT_DEFAULT = 8;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_DCACHE = 2'd1,
        A_ICACHE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: counts cycles the icache is denied and
// flags when it has waited long enough to be forced to win arbitration.
module arb_starve_ctr #(
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM_V = CW'(LIMIT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt;

    // Clear wins over increment; the count holds once the limit is reached.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM_V)) begin
            cnt <= cnt + ONE;
        end
    end

    assign limit_hit = (cnt >= LIM_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester RAM port arbiter between the icache and dcache. The dcache
// has priority, but a starved icache is forced through between dcache words.
// Ownership is held for one RAM word access so a transfer is never torn.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    arb_state_t state;
    arb_state_t next_state;
    arb_state_t owner;
    logic       d_req;
    logic       done;
    logic       starve_hit;
    logic       starve_inc;
    logic       starve_clr;

    assign d_req = dREN | dWEN;
    assign done  = (ramstate == ACCESS);

    // Effective owner: the latched owner mid-access, otherwise a fresh
    // zero-cycle arbitration. Forced to none while reset is asserted so the
    // RAM port drops immediately.
    always_comb begin
        owner = A_IDLE;
        if (!nRST) begin
            owner = A_IDLE;
        end else if (state != A_IDLE) begin
            owner = state;
        end else if (iREN && starve_hit) begin
            owner = A_ICACHE;
        end else if (d_req) begin
            owner = A_DCACHE;
        end else if (iREN) begin
            owner = A_ICACHE;
        end
    end

    // RAM port mux and per-cache wait generation; a dcache write beats a read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (owner)
            A_DCACHE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~done;
            end
            A_ICACHE: begin
                ramaddr  = iaddr;
                ramREN   = 1'b1;
                iwait    = ~done;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

    // Release ownership on completion or when the owner abandons its request.
    always_comb begin
        next_state = owner;
        case (owner)
            A_DCACHE: if (done || !d_req) next_state = A_IDLE;
            A_ICACHE: if (done || !iREN)  next_state = A_IDLE;
            default:  next_state = A_IDLE;
        endcase
    end

    // Owner state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= A_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sticky error flag for any RAM ERROR seen while the port is owned.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ram_err <= 1'b0;
        end else if ((owner != A_IDLE) && (ramstate == ERROR)) begin
            ram_err <= 1'b1;
        end
    end

    assign starve_inc = iREN && (owner != A_ICACHE);
    assign starve_clr = !iREN || ((owner == A_ICACHE) && done);

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit_hit(starve_hit)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, a cycle-level reference model
// checked on every falling edge, and literal expectations for key cycles.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIM = 8;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ram_err;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .ram_err (ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner is 0=none, 1=dcache, 2=icache.
    int    m_own    = 0;
    int    m_starve = 0;
    bit    m_err    = 0;
    int    e_own;
    bit    e_ren, e_wen, e_done, e_req;
    word_t e_addr, e_store;

    always @(negedge CLK) begin
        if (!nRST) begin
            m_own = 0; m_starve = 0; m_err = 0;
            chk1("rst_ramREN", ramREN, 1'b0);
            chk1("rst_ramWEN", ramWEN, 1'b0);
            chk32("rst_ramaddr", ramaddr, 32'h0);
            chk1("rst_iwait", iwait, 1'b1);
            chk1("rst_dwait", dwait, 1'b1);
            chk1("rst_ram_err", ram_err, 1'b0);
        end else begin
            if (m_own != 0)                  e_own = m_own;
            else if (iREN && m_starve >= LIM) e_own = 2;
            else if (dREN || dWEN)           e_own = 1;
            else if (iREN)                   e_own = 2;
            else                             e_own = 0;
            e_done = (ramstate == ACCESS);
            e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
            if (e_own == 1) begin
                e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
            end else if (e_own == 2) begin
                e_addr = iaddr; e_ren = 1;
            end
            chk1("m_ramREN", ramREN, e_ren);
            chk1("m_ramWEN", ramWEN, e_wen);
            chk32("m_ramaddr", ramaddr, e_addr);
            chk32("m_ramstore", ramstore, e_store);
            chk1("m_iwait", iwait, !(e_own == 2 && e_done));
            chk1("m_dwait", dwait, !(e_own == 1 && e_done));
            chk32("m_iload", iload, ramload);
            chk32("m_dload", dload, ramload);
            chk1("m_ram_err", ram_err, m_err);
            // advance model to the next cycle
            if (e_own != 0 && ramstate == ERROR) m_err = 1;
            e_req = (e_own == 1) ? (dREN || dWEN) : iREN;
            if (e_own == 0 || e_done || !e_req) m_own = 0;
            else                                m_own = e_own;
            if (!iREN || (e_own == 2 && e_done)) m_starve = 0;
            else if (e_own != 2 && m_starve < LIM) m_starve = m_starve + 1;
        end
    end

    task automatic drive(input logic ir, input word_t ia, input logic dr, input logic dw,
                         input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        @(posedge CLK);
        #1;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    // Writeback/fill scenario bookkeeping
    word_t seq_addr [4] = '{32'h1000, 32'h1004, 32'h1000, 32'h1004};
    int    w, bcnt, first_i;
    bit    active;
    word_t obs_addr [24];
    int    dlow [$];

    initial begin
        nRST = 1'b0;
        iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = 32'hDEADBEEF;
        repeat (2) @(posedge CLK);
        #1;
        chk1("reset_iwait", iwait, 1'b1);
        chk1("reset_dwait", dwait, 1'b1);
        chk1("reset_ramREN", ramREN, 1'b0);
        chk32("reset_iload", iload, 32'hDEADBEEF);
        nRST = 1'b1;

        // isolated icache read, two BUSY then ACCESS
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h11112222);
        chk32("ird_addr", ramaddr, 32'h40);
        chk1("ird_ren", ramREN, 1'b1);
        chk1("ird_wait0", iwait, 1'b1);
        drive(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h11112222);
        chk1("ird_wait1", iwait, 1'b1);
        drive(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h11112222);
        chk1("ird_wait2", iwait, 1'b0);
        chk32("ird_load", iload, 32'h11112222);
        chk1("ird_dwait", dwait, 1'b1);
        idle();
        chk1("idle_ren", ramREN, 1'b0);

        // contention: dcache wins, icache follows at 0x0
        drive(1, 32'h0, 1, 0, 32'h100, 0, BUSY, 32'h0);
        chk32("cont_addr", ramaddr, 32'h100);
        chk1("cont_iwait", iwait, 1'b1);
        drive(1, 32'h0, 1, 0, 32'h100, 0, ACCESS, 32'hAAAA5555);
        chk1("cont_dwait", dwait, 1'b0);
        chk32("cont_dload", dload, 32'hAAAA5555);
        chk1("cont_iwait2", iwait, 1'b1);
        drive(1, 32'h0, 0, 0, 32'h100, 0, ACCESS, 32'h0);
        chk32("cont_iaddr", ramaddr, 32'h0);
        chk1("cont_iren", ramREN, 1'b1);
        chk1("cont_igrant", iwait, 1'b0);
        idle();

        // read and write together: write wins
        drive(0, 0, 1, 1, 32'h300, 32'hCAFEF00D, ACCESS, 32'h0);
        chk1("rw_wen", ramWEN, 1'b1);
        chk1("rw_ren", ramREN, 1'b0);
        chk32("rw_store", ramstore, 32'hCAFEF00D);
        chk1("rw_dwait", dwait, 1'b0);
        idle();

        // abort: dcache drops its request while RAM is BUSY
        drive(0, 0, 1, 0, 32'h200, 0, BUSY, 32'h0);
        chk32("abort_addr0", ramaddr, 32'h200);
        drive(0, 0, 0, 0, 32'h200, 0, BUSY, 32'h0);
        chk32("abort_held_addr", ramaddr, 32'h200);
        chk1("abort_dwait", dwait, 1'b1);
        drive(0, 0, 0, 0, 32'h200, 0, FREE, 32'h0);
        chk32("abort_addr2", ramaddr, 32'h0);
        chk1("abort_ren2", ramREN, 1'b0);

        // zero-cycle grant and completion
        drive(0, 0, 1, 0, 32'h10, 0, ACCESS, 32'h12345678);
        chk1("zc_dwait", dwait, 1'b0);
        chk32("zc_dload", dload, 32'h12345678);
        idle();

        // error during icache access, then reset mid-access
        drive(1, 32'h44, 0, 0, 0, 0, ERROR, 32'h0);
        chk1("err_iwait", iwait, 1'b1);
        drive(1, 32'h44, 0, 0, 0, 0, BUSY, 32'h0);
        chk1("err_flag", ram_err, 1'b1);
        chk1("err_iwait2", iwait, 1'b1);
        @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        chk1("arst_err", ram_err, 1'b0);
        chk1("arst_ren", ramREN, 1'b0);
        chk1("arst_iwait", iwait, 1'b1);
        idle();
        @(posedge CLK);
        #1 nRST = 1'b1;
        idle();

        // dcache writeback A/B then fill A/B, 4 cycles per word, icache starving
        w = 0; bcnt = 0; first_i = -1;
        for (int c = 0; c < 24; c++) begin
            @(posedge CLK);
            #1;
            iREN = 1; iaddr = 32'h80; ramload = 32'h0;
            if (w < 4) begin
                dWEN = (w < 2); dREN = (w >= 2); daddr = seq_addr[w]; dstore = 32'hB0 + 32'(w);
            end else begin
                dWEN = 0; dREN = 0; daddr = '0; dstore = '0;
            end
            #1;
            active = ramREN || ramWEN;
            ramstate = !active ? FREE : (bcnt == 3) ? ACCESS : BUSY;
            @(negedge CLK);
            obs_addr[c] = ramaddr;
            if (!dwait) begin
                dlow.push_back(c);
                w++;
            end
            if (!iwait && first_i < 0) first_i = c;
            if (active && ramstate == ACCESS) bcnt = 0;
            else if (active)                  bcnt++;
            else                              bcnt = 0;
        end
        chk32("wb_all_words", 32'(w), 32'd4);
        chk32("wb_first_igrant", 32'(first_i), 32'd11);
        chk32("wb_addr_c7", obs_addr[7], 32'h1004);
        chk32("wb_addr_c8", obs_addr[8], 32'h80);
        chk32("wb_dlow_count", 32'(dlow.size()), 32'd4);
        if (dlow.size() == 4) begin
            chk32("wb_dlow0", 32'(dlow[0]), 32'd3);
            chk32("wb_dlow1", 32'(dlow[1]), 32'd7);
            chk32("wb_dlow2", 32'(dlow[2]), 32'd15);
            chk32("wb_dlow3", 32'(dlow[3]), 32'd19);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Sits directly downstream of the instruction and data caches and upstream of the single-ported RAM.
- Merges the icache request channel and the dcache request channel onto one RAM port, and returns wait/load data to whichever cache owns the port.
- The dcache has priority. A bounded starvation counter guarantees icache forward progress during long dcache fill/writeback sequences.
- Ownership is held for the duration of one RAM word access, so a transfer is never torn between requesters.

## Interface
Parameters:
- STARVE_LIMIT, default 8: consecutive cycles icache may be denied before it is forced to win the next arbitration.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address (word_t)
- iwait  out  1  high while icache access not complete
- iload  out  32  RAM read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  high while dcache access not complete
- dload  out  32  RAM read data to dcache
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_err  out  1  sticky flag, set on any ERROR cycle during an owned access

## Operation
- **Registered owner state:** A_IDLE, A_DCACHE, A_ICACHE.
- **Effective owner each cycle:**
  - equals the state when the state is not A_IDLE;
  - otherwise equals the arbitration result.
- **Arbitration (from A_IDLE), in priority order:**
  - iREN and starve_cnt ≥ STARVE_LIMIT → icache;
  - else (dREN|dWEN) → dcache;
  - else iREN → icache;
  - else none.
- **RAM drive, owner dcache:**
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are asserted).
- **RAM drive, owner icache:**
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- **RAM drive, no owner:** all ram* outputs 0.
- **Wait signals:**
  - dwait = ~(owner==dcache && ramstate==ACCESS);
  - iwait = ~(owner==icache && ramstate==ACCESS).
- **Load data:** iload = dload = ramload, unconditionally.
- **Next state:**
  - Owned access completes (ramstate==ACCESS) → A_IDLE. Arbitration reruns the following cycle, so back-to-back dcache words (block fill A/B, dirty clean A/B) are each arbitrated separately.
  - Owner drops its request before completion → A_IDLE; abort, no response.
  - Otherwise the state latches the effective owner.
- **starve_cnt (saturating at STARVE_LIMIT):**
  - increments on a cycle with iREN=1 and owner≠icache;
  - clears on icache completion or when iREN=0.
- **ramstate==ERROR:** treated as not-ACCESS (wait stays high), and sets ram_err.

## Timing
- **Reset values:** state A_IDLE, starve_cnt 0, ram_err 0, ram* 0, iwait=dwait=1, loads track ramload.
- **Zero-cycle grant:** request → ram* is combinational in A_IDLE. An access served by RAM with ACCESS in the same cycle completes in 1 cycle.
- **Mid-access behaviour:** owner address/data changes pass through combinationally; ownership is not re-evaluated.
- **Simultaneous iREN and dREN with starve_cnt < limit:** dcache wins; iwait held high; starve_cnt+1.
- **Reset mid-access:** outputs return immediately to reset values; no partial completion is signalled.
- **Handshake:** a cache must hold its request and address stable until its wait is low for one cycle.

## Structure
- **cpu_types_pkg** holds:
  - ramstate_t (existing);
  - new arb_state_t enum {A_IDLE, A_DCACHE, A_ICACHE}, 2 bits;
  - the STARVE_LIMIT default constant.
- **Sub-module arb_starve_ctr:** saturating counter with inc, clr and limit-reached output. It is the only natural split; the FSM and muxing stay in mem_arbiter.

## Test plan
- **Isolated icache read:** iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles → iwait low on cycle 3, iload=ramload, dwait stays 1.
- **Contention:** iREN and dREN both at cycle 0, daddr=0x100 → ramaddr=0x100 until dcache ACCESS; the next cycle re-arbitrates, and with dREN low icache is granted at 0x0.
- **dcache writeback then fill:** dWEN A/B then dREN A/B, with RAM taking 4 cycles per word and iREN held high → icache is granted as soon as starve_cnt reaches 8, between dcache words, never mid-word.
- **dREN and dWEN both high:** ramWEN=1, ramREN=0, ramstore=dstore.
- **Abort:** the owner drops its request while RAM is BUSY → state A_IDLE next cycle, ram* 0.
- **Error and reset:** ramstate=ERROR during an icache access → ram_err=1 and iwait=1; nRST pulsed mid-access → ram_err=0, ramREN=0 asynchronously.
